load_store_unit: RTL
====================

# load_store_unit

Sits between the execute stage and the `memory` block. Converts byte-addressed load/store requests (byte, half, word; signed or unsigned loads) into the word-indexed `memory` port. Sub-word stores are done as read-modify-write. Decodes the ROM/RAM region into `mem_type` and flags misaligned, out-of-range and illegal accesses without touching memory.

## Interface
Parameters:
- ROM_BASE, 32'h0000_0000, byte base address of the ROM region
- RAM_BASE, 32'h0000_1000, byte base address of the RAM region
- DEPTH_WORDS, 64, words per region; index width is clog2(DEPTH_WORDS)

Ports:
- clock  in  1  single clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; access rejected
- mem_address  out  32  word index within region, zero-extended
- mem_wdata  out  32  word to write
- mem_write  out  1  write strobe; memory writes on posedge
- mem_read  out  1  read strobe; memory drives output_data at negedge
- mem_type  out  1  `MEM_ROM` / `MEM_RAM` encoding
- mem_rdata  in  32  memory output_data

## Operation
- States: IDLE, READ, WRITE, RESP.
- Acceptance: `req_valid && req_ready` at a posedge latches the request into holding registers. Request inputs are ignored after that edge.
- Region decode:
  - In ROM if `ROM_BASE <= addr < ROM_BASE + 4*DEPTH_WORDS`.
  - Else in RAM if the same test holds for RAM_BASE.
  - Else error.
  - Index = (addr − base) >> 2. Byte lane = addr[1:0].
- Error checks, in priority order:
  - req_size == 3
  - Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0
  - Out of range
  - Store to ROM (see Configuration)
- Any error: IDLE→RESP with resp_err = 1 and resp_rdata = 0. mem_read and mem_write are never asserted for an errored request.
- Load: IDLE→READ→RESP.
  - In READ, mem_read = 1.
  - mem_rdata is captured at the posedge ending READ.
  - The byte or half at the lane is extracted and extended per req_unsigned.
- Word store: IDLE→WRITE→RESP. In WRITE, mem_write = 1 and mem_wdata = req_wdata.
- Byte/half store: IDLE→READ→WRITE→RESP.
  - The WRITE word is the captured read word with only the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- mem_address and mem_type hold their values from READ through WRITE.

## Timing
- Reset values while reset_n = 0:
  - state = IDLE; req_ready = 1 after release
  - mem_read = mem_write = 0; mem_address = mem_wdata = 0; mem_type = `MEM_ROM`
  - resp_valid = resp_err = 0; resp_rdata = 0
- Reset is asynchronous. Asserting it mid-operation drops mem_write immediately, so no partial write occurs if reset_n falls before the WRITE posedge. The pending request is discarded with no response.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- mem_read and mem_write are registered outputs and never high in the same cycle.
- Back-to-back operation: req_ready rises in the cycle after RESP. Maximum throughput is one access per 3 cycles (word store or load).

## Configuration
- LSU_ROM_WRITE_EN
  - Defined: stores to the ROM region are legal and executed like RAM stores (used for program loading).
  - Undefined: any store decoded to ROM completes with resp_err = 1 and no memory access. ROM loads are unaffected.

## Test plan
- SW 0xDEADBEEF to 0x1008, then LW 0x1008 -> mem_address = 2, mem_type = RAM; resp_rdata = 0xDEADBEEF, resp_err = 0, each response 2 cycles after its accept edge.
- After the above, SB 0x5A to 0x1009, then LW 0x1008 -> READ then WRITE with mem_wdata = 0xDEAD5AEF; load returns 0xDEAD5AEF; store response 3 cycles after accept.
- Word 0x0000_80F0 at 0x1000: LB 0x1000 -> 0xFFFFFFF0; LBU 0x1000 -> 0x000000F0; LH 0x1000 -> 0xFFFF80F0; LHU 0x1000 -> 0x000080F0.
- LH 0x1001, LW 0x1002, LW 0x2000, req_size = 3 -> each gives resp_err = 1, resp_rdata = 0, no mem_read or mem_write pulse, 1-cycle latency.
- SW 0x12345678 to 0x0004 (ROM):
  - without LSU_ROM_WRITE_EN -> resp_err = 1, no mem_write, LW 0x0004 returns the original ROM word;
  - with LSU_ROM_WRITE_EN -> LW 0x0004 returns 0x12345678.
- Drop reset_n during the WRITE cycle of SB to 0x1010 -> mem_write falls immediately, word at index 4 unchanged, no resp_valid; req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Bridges execute-stage byte-addressed load/store requests onto the word-indexed
// memory port. Loads of byte/half/word are extracted from the read word and sign-
// or zero-extended. Sub-word stores are performed as read-modify-write. The ROM/RAM
// region is decoded onto mem_type; illegal size, misaligned and out-of-range
// accesses complete with resp_err and never strobe memory.
//
// Optional feature macro: LSU_ROM_WRITE_EN
//   defined   - stores decoded to ROM are executed like RAM stores
//   undefined - stores decoded to ROM are rejected with resp_err
//
// Ports:
//   clock, reset_n              clock (posedge) and asynchronous active-low reset
//   req_valid / req_ready       request handshake; ready only while idle
//   req_write, req_size         1 = store; 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned                loads: zero-extend when set
//   req_addr, req_wdata         byte address, right-aligned store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        extended load data (0 otherwise), rejection flag
//   mem_address, mem_type       word index within region, ROM/RAM select
//   mem_read, mem_write         registered strobes, never high together
//   mem_wdata, mem_rdata        write word, memory read word

`ifndef MEM_ROM
`define MEM_ROM 1'b0
`endif
`ifndef MEM_RAM
`define MEM_RAM 1'b1
`endif

module load_store_unit #(
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_type,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] REGION_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e state_q, state_d;

  // Holding registers for the accepted request
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Registered memory-side outputs
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_type_q, mem_type_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  // Request decode
  logic [31:0] rom_off, ram_off, word_index;
  logic        in_rom, in_ram;
  logic        size_illegal, misaligned, out_of_range, rom_store_err, req_err;
  logic        accept;

  always_comb begin
    rom_off      = req_addr - ROM_BASE;
    ram_off      = req_addr - RAM_BASE;
    // Unsigned offset compare covers both bounds of the region at once
    in_rom       = rom_off < REGION_BYTES;
    in_ram       = !in_rom && (ram_off < REGION_BYTES);
    word_index   = (in_rom ? rom_off : ram_off) >> 2;
    size_illegal = (req_size == 2'd3);
    misaligned   = ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    out_of_range = !in_rom && !in_ram;
`ifdef LSU_ROM_WRITE_EN
    rom_store_err = 1'b0;
`else
    rom_store_err = in_rom && req_write;
`endif
    req_err      = size_illegal || misaligned || out_of_range || rom_store_err;
  end

  assign accept = (state_q == StIdle) && req_valid;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = StResp;
          end else if (!req_write) begin
            state_d = StRead;
          end else if (req_size == 2'd2) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = write_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Load data extraction and sub-word merge, both from the word read in READ
  logic [31:0] lane_shift, load_ext, merged;

  always_comb begin
    lane_shift = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'h0, lane_shift[7:0]}
                                     : {{24{lane_shift[7]}}, lane_shift[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'h0, lane_shift[15:0]}
                                     : {{16{lane_shift[15]}}, lane_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == 2'd0) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Datapath next-state
  always_comb begin
    write_d       = write_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_type_d    = mem_type_q;

    if (accept) begin
      write_d    = req_write;
      size_d     = req_size;
      unsigned_d = req_unsigned;
      lane_d     = req_addr[1:0];
      wdata_d    = req_wdata[15:0];
      err_d      = req_err;
      rdata_d    = 32'h0;
      // Errored requests leave the memory-side registers untouched
      if (!req_err) begin
        mem_address_d = word_index;
        mem_type_d    = in_rom ? `MEM_ROM : `MEM_RAM;
        if (req_write && (req_size == 2'd2)) begin
          mem_wdata_d = req_wdata;
        end
      end
    end

    if (state_q == StRead) begin
      if (write_q) begin
        mem_wdata_d = merged;
      end else begin
        rdata_d = load_ext;
      end
    end

    // Strobes are registered copies of the state being entered
    mem_read_d  = (state_d == StRead);
    mem_write_d = (state_d == StWrite);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      lane_q        <= 2'd0;
      wdata_q       <= 16'h0;
      err_q         <= 1'b0;
      rdata_q       <= 32'h0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_type_q    <= `MEM_ROM;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      write_q       <= write_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_type_q    <= mem_type_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StResp);
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = resp_valid ? rdata_q : 32'h0;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_type    = mem_type_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;

endmodule
